// File: rtl/fix_mul_if.sv
// fix_mul_if: operand/result bus for the sequential fixed-point multiplier.
// The master issues operands and start; the slave returns product, overflow
// and the complete (idle / result valid) flag.
interface fix_mul_if #(
  parameter int N = 16
);
  logic [N-1:0] multiplicand;
  logic [N-1:0] multiplier;
  logic         start;
  logic [N-1:0] product_out;
  logic         complete;
  logic         overflow;

  modport master (
    output multiplicand,
    output multiplier,
    output start,
    input  product_out,
    input  complete,
    input  overflow
  );

  modport slave (
    input  multiplicand,
    input  multiplier,
    input  start,
    output product_out,
    output complete,
    output overflow
  );
endinterface

// File: rtl/fix_mul.sv
// fix_mul: sequential sign-magnitude Q-format multiplier.
// Shift-and-add, one multiplier bit per cycle; N-cycle latency from an
// accepted start to complete. The product keeps bits [Q+N-2:Q] of the full
// magnitude (truncated toward zero) and flags overflow when higher bits are set.
// Optional build macro FIX_MUL_SAT_EN: saturate the magnitude on overflow
// instead of wrapping.
module fix_mul #(
  parameter int Q = 8,
  parameter int N = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  fix_mul_if.slave  bus
);

  localparam int M  = N - 1;          // magnitude width
  localparam int AW = 2 * M;          // full product width
  localparam int CW = $clog2(N - 1);  // holds N-2 for every N >= 4

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [M-1:0]   a_mag_r, a_mag_s;
  logic [M-1:0]   b_mag_r, b_mag_s;
  logic           sign_r, sign_s;
  logic [AW-1:0]  acc_r, acc_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [N-1:0]   prod_r, prod_s;
  logic           ovf_r, ovf_s;
  logic           cpl_r, cpl_s;

  logic [AW-1:0]  addend_s;
  logic [M-1:0]   raw_s;
  logic [M-1:0]   mag_s;
  logic           ovf_fin_s;

  // Result shaping: truncate, detect overflow, apply wrap or saturation.
  always_comb begin
    addend_s  = {{M{1'b0}}, a_mag_r} << cnt_r;
    raw_s     = acc_r[Q+N-2:Q];
    ovf_fin_s = |acc_r[AW-1:Q+N-1];
`ifdef FIX_MUL_SAT_EN
    if (ovf_fin_s) begin
      mag_s = {M{1'b1}};
    end else begin
      mag_s = raw_s;
    end
`else
    mag_s = raw_s;
`endif
  end

  // Next-state and datapath updates for the IDLE/MUL/FIN sequence.
  always_comb begin
    state_s = state_r;
    a_mag_s = a_mag_r;
    b_mag_s = b_mag_r;
    sign_s  = sign_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    prod_s  = prod_r;
    ovf_s   = ovf_r;
    cpl_s   = cpl_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          a_mag_s = bus.multiplicand[M-1:0];
          b_mag_s = bus.multiplier[M-1:0];
          sign_s  = bus.multiplicand[N-1] ^ bus.multiplier[N-1];
          acc_s   = '0;
          cnt_s   = '0;
          cpl_s   = 1'b0;
          state_s = ST_MUL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (b_mag_r[cnt_r]) begin
          acc_s = acc_r + addend_s;
        end else begin
          acc_s = acc_r;
        end
        if (cnt_r == CW'(N - 2)) begin
          state_s = ST_FIN;
        end else begin
          cnt_s   = cnt_r + CW'(1);
          state_s = ST_MUL;
        end
      end
      ST_FIN: begin
        // A zero magnitude always carries a positive sign.
        prod_s  = {sign_r & (|mag_s), mag_s};
        ovf_s   = ovf_fin_s;
        cpl_s   = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        cpl_s   = 1'b1;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      a_mag_r <= '0;
      b_mag_r <= '0;
      sign_r  <= 1'b0;
      acc_r   <= '0;
      cnt_r   <= '0;
      prod_r  <= '0;
      ovf_r   <= 1'b0;
      cpl_r   <= 1'b1;
    end else begin
      state_r <= state_s;
      a_mag_r <= a_mag_s;
      b_mag_r <= b_mag_s;
      sign_r  <= sign_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      prod_r  <= prod_s;
      ovf_r   <= ovf_s;
      cpl_r   <= cpl_s;
    end
  end

  assign bus.product_out = prod_r;
  assign bus.overflow    = ovf_r;
  assign bus.complete    = cpl_r;

endmodule

// File: tb/tb_fix_mul.sv
// tb_fix_mul: scoreboard bench for fix_mul (Q=8, N=16). Expected results come
// from an integer-arithmetic model and are queued at issue time; a monitor
// pops and compares whenever complete rises.
module tb_fix_mul;

  localparam int Q = 8;
  localparam int N = 16;

  typedef struct packed {
    logic [N-1:0] prod;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst_n;

  fix_mul_if #(.N(N)) bus ();

  fix_mul #(.Q(Q), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full product of magnitudes, drop Q fraction bits.
  function automatic exp_t ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    longint unsigned p;
    logic [N-2:0]    mag;
    logic            ovf;
    exp_t            r;
    p   = (longint'(a[N-2:0]) * longint'(b[N-2:0])) >> Q;
    ovf = (p >= (64'd1 << (N - 1)));
    mag = p[N-2:0];
`ifdef FIX_MUL_SAT_EN
    if (ovf) mag = {(N-1){1'b1}};
`endif
    r.prod = {(a[N-1] ^ b[N-1]) && (mag != '0), mag};
    r.ovf  = ovf;
    return r;
  endfunction

  // Monitor state
  logic         prev_cpl  = 1'b1;
  int           busy_cnt  = 0;
  logic [N-1:0] held_prod = '0;
  logic         held_ovf  = 1'b0;

  // Monitor: checks hold-while-busy, latency and result on each rise of complete.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cpl  = 1'b1;
      busy_cnt  = 0;
      held_prod = '0;
      held_ovf  = 1'b0;
    end else begin
      if (!bus.complete) begin
        busy_cnt++;
        checks++;
        if (bus.product_out !== held_prod || bus.overflow !== held_ovf) begin
          errors++;
          $display("FAIL hold: product_out=%h overflow=%b required %h/%b while busy",
                   bus.product_out, bus.overflow, held_prod, held_ovf);
        end
      end else if (!prev_cpl) begin
        exp_t e;
        checks++;
        if (busy_cnt != N) begin
          errors++;
          $display("FAIL latency: busy %0d cycles required %0d", busy_cnt, N);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: product_out=%h with no pending operation",
                   bus.product_out);
        end else begin
          e = exp_q.pop_front();
          if (bus.product_out !== e.prod || bus.overflow !== e.ovf) begin
            errors++;
            $display("FAIL result: product_out=%h overflow=%b required %h/%b",
                     bus.product_out, bus.overflow, e.prod, e.ovf);
          end
          held_prod = e.prod;
          held_ovf  = e.ovf;
        end
        busy_cnt = 0;
      end
      prev_cpl = bus.complete;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!bus.complete && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.complete) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: complete=%b required 1", bus.complete);
    end
  endtask

  // Issue one operation with a single-cycle start pulse.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b);
    wait_idle();
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.start        = 1'b1;
    exp_q.push_back(ref_mul(a, b));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (bus.complete !== 1'b1 || bus.product_out !== '0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s: complete=%b product_out=%h overflow=%b required 1/0000/0",
               tag, bus.complete, bus.product_out, bus.overflow);
    end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] a, b;
    int mode;
    int n;

    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset_state");
    rst_n = 1'b1;

    // Directed cases
    do_op(16'h0180, 16'h0200);   // 0x0300
    do_op(16'h8180, 16'h0200);   // 0x8300
    do_op(16'h8180, 16'h8200);   // 0x0300
    do_op(16'h7F00, 16'h0200);   // overflow
    do_op(16'h8001, 16'h0080);   // truncates to zero, sign cleared
    do_op(16'h7FFF, 16'h7FFF);   // maximum magnitudes
    do_op(16'h0000, 16'h8123);   // zero operand, negative sign

    // Busy start: new operands mid-operation are ignored
    do_op(16'h0300, 16'h0300);   // 0x0900
    repeat (4) @(negedge clk);
    bus.multiplicand = 16'h1234;
    bus.multiplier   = 16'h5678;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    // Randomised operations
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      a = 16'($urandom);
      b = 16'($urandom);
      if (mode == 1) begin
        a = a & 16'h83FF;
        b = b & 16'h83FF;
      end else if (mode == 2) begin
        b = b & 16'h8000;
      end
      do_op(a, b);
    end

    // Back-to-back with start held high
    wait_idle();
    bus.multiplicand = 16'h0280;
    bus.multiplier   = 16'h8140;
    bus.start        = 1'b1;
    exp_q.push_back(ref_mul(16'h0280, 16'h8140));
    exp_q.push_back(ref_mul(16'h0280, 16'h8140));
    @(negedge clk);
    wait_idle();
    @(negedge clk);
    checks++;
    if (bus.complete !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: complete=%b required 0 one cycle after result", bus.complete);
    end
    bus.start = 1'b0;

    // Reset in the middle of an operation
    do_op(16'h0500, 16'h0700);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_mid_op");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0100, 16'h0100);   // 0x0100

    // Drain outstanding results
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding required 0", exp_q.size());
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fix_mul.md
# fix_mul

Sequential sign-magnitude fixed-point multiplier for the Q-format datapath. It is the inverse-operation companion of the fixed-point divider and uses the same number format and the same start/complete handshake. It is built on a shift-and-add loop with one multiplier bit per cycle. It produces a truncated N-bit product plus an overflow flag, for blocks that scale values back after division.

## Interface
- `Q`, default 8: number of fractional bits.
- `N`, default 16: total word width. Bit N-1 is the sign; bits N-2..0 are the magnitude, with Q fractional bits.
- `clk`  input  1  sole clock; all state changes on the rising edge.
- `rst_n`  input  1  reset. Asynchronous assert, active-low.
- `multiplicand`  input  N  sign-magnitude operand A. Sampled only when a start is accepted.
- `multiplier`  input  N  sign-magnitude operand B. Sampled only when a start is accepted.
- `start`  input  1  request. Accepted only on an edge where `complete`=1.
- `product_out`  output  N  sign-magnitude result. Valid while `complete`=1; held until the next accepted start.
- `complete`  output  1  1 = idle with result valid; 0 = busy.
- `overflow`  output  1  1 = true magnitude exceeded N-1 bits. Valid and held together with `product_out`.

## Operation
- State machine: IDLE, MUL, FIN.
- IDLE (`complete`=1):
  - `start`=1 latches |A| and |B| (N-1 bits each) and sign = A[N-1] XOR B[N-1].
  - Clears a 2(N-1)-bit accumulator.
  - Loads the bit counter with 0 and goes to MUL.
- MUL: one iteration per cycle, i = 0..N-2.
  - If bit i of |B| is 1, add |A| << i to the accumulator.
  - When i = N-2, go to FIN.
  - The counter is wide enough to hold N-2 for any legal N (N ≥ 4, Q ≤ N-2).
- FIN: one cycle.
  - Raw magnitude = accumulator[Q+N-2:Q]. This truncates the low Q bits toward zero; there is no rounding.
  - overflow = OR of accumulator bits above Q+N-2.
  - Magnitude on overflow depends on configuration (see Configuration).
  - If the final magnitude is 0, the sign is forced to 0, so the block never outputs negative zero.
  - Register `product_out` and `overflow`, then return to IDLE.
- `start` while busy is ignored; it is not queued.
- Operand changes while busy have no effect.
- Reset, including mid-operation: aborts any operation and sends the FSM to IDLE.
  - `complete`=1, `product_out`=0, `overflow`=0.
  - The accumulator and counter are cleared.

## Timing
- Reset values: `complete`=1, `product_out`=0, `overflow`=0.
- Let E0 be the edge that accepts `start`.
- `complete` falls after E0.
- The MUL iterations occupy edges E0+1 .. E0+N-1; FIN is edge E0+N.
- `complete` rises, with `product_out` and `overflow` updated, after edge E0+N. Latency = N cycles (16 at the default).
- `product_out` and `overflow` keep their previous values until FIN; they do not change while busy.
- Back-to-back: if `start` is held high, the next operation is accepted on edge E0+N+1 (one IDLE cycle between operations).
- Reset assertion acts immediately, without waiting for a clock. Release is synchronous to `clk`; the first start can be accepted on the first edge after release.

## Configuration
- Macro: `FIX_MUL_SAT_EN`.
- Defined: on overflow the magnitude saturates to all ones (N-1 bits). The sign is kept; for example, the positive result is 0x7FFF at the default size.
- Undefined: on overflow the magnitude is the raw truncated bits accumulator[Q+N-2:Q] (wrap).
- In both builds the `overflow` port exists and behaves identically.

## Test plan
All values use Q=8, N=16.
- Basic: A=0x0180 (1.5), B=0x0200 (2.0), pulse `start` → `complete` low for 16 cycles, then `product_out`=0x0300, `overflow`=0.
- Sign: A=0x8180 (-1.5), B=0x0200 → 0x8300. A=0x8180, B=0x8200 → 0x0300.
- Overflow: A=0x7F00 (127.0), B=0x0200 → `overflow`=1. Result is 0x7FFF with `FIX_MUL_SAT_EN` and 0x7E00 without it.
- Truncation and zero: A=0x8001 (-2^-8), B=0x0080 (0.5) → `product_out`=0x0000 (sign cleared), `overflow`=0.
- Busy start: pulse `start` with new operands at cycle 5 of an operation → ignored; the original result appears at cycle 16.
- Reset mid-operation: drop `rst_n` at cycle 7 → `complete`=1, `product_out`=0, `overflow`=0 immediately. After release, a new 0x0100×0x0100 operation gives 0x0100.
